// File: rtl/window_position_gen.sv
// Scans one 256-sample frame per trigger, finds up to three hysteresis regions
// at least MIN_WIDTH samples long and publishes their start/end indices.
module window_position_gen #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned MIN_WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_in_valid,
  input  logic [DATA_W-1:0] th_high,
  input  logic [DATA_W-1:0] th_low,
  output logic [7:0]        start_position_1,
  output logic [7:0]        start_position_2,
  output logic [7:0]        start_position_3,
  output logic [7:0]        end_position_1,
  output logic [7:0]        end_position_2,
  output logic [7:0]        end_position_3,
  output logic              position_3_error_sig,
  output logic              position_gen_en,
  output logic              busy
);

  localparam int unsigned IDX_W = 8;
  localparam int unsigned CNT_W = 3;
  localparam int unsigned WID_W = IDX_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = 8'hFF;

  typedef enum logic [1:0] {IDLE, SCAN, FINISH} state_t;

  state_t                  r_state;
  logic [IDX_W-1:0]        r_idx;
  logic [IDX_W-1:0]        r_cand_start;
  logic [IDX_W-1:0]        r_cl_start;
  logic [IDX_W-1:0]        r_cl_end;
  logic                    r_cl_vld;
  logic                    r_in_region;
  logic                    r_last;
  logic [DATA_W-1:0]       r_th_high;
  logic [DATA_W-1:0]       r_th_low;
  logic [2:0][IDX_W-1:0]   r_sh_start;
  logic [2:0][IDX_W-1:0]   r_sh_end;
  logic [CNT_W-1:0]        r_count;

  logic                    w_start_beat;
  logic                    w_beat;
  logic                    w_proc;
  logic                    w_in;
  logic                    w_in_next;
  logic                    w_close;
  logic                    w_accept;
  logic [IDX_W-1:0]        w_idx;
  logic [IDX_W-1:0]        w_cs_next;
  logic [IDX_W-1:0]        w_close_start;
  logic [IDX_W-1:0]        w_close_end;
  logic [DATA_W-1:0]       w_thh;
  logic [DATA_W-1:0]       w_thl;
  logic [WID_W-1:0]        w_width;

  // A start beat (from IDLE, or a restart mid-scan) is processed as index 0 with live thresholds
  assign w_start_beat = data_in_valid & frame_start &
                        ((r_state == IDLE) | ((r_state == SCAN) & ~r_last));
  assign w_beat       = data_in_valid & ~frame_start & (r_state == SCAN) & ~r_last;
  assign w_proc       = w_start_beat | w_beat;
  assign w_idx        = w_start_beat ? '0 : r_idx;
  assign w_thh        = w_start_beat ? th_high : r_th_high;
  assign w_thl        = w_start_beat ? th_low : r_th_low;
  assign w_in         = ~w_start_beat & r_in_region;

  // Hysteresis tracker: produces a close event for the current beat
  always_comb begin
    w_in_next     = w_in;
    w_cs_next     = r_cand_start;
    w_close       = 1'b0;
    w_close_start = r_cand_start;
    w_close_end   = w_idx;
    if (!w_in) begin
      if (data_in >= w_thh) begin
        w_in_next = 1'b1;
        w_cs_next = w_idx;
        if (w_idx == LAST_IDX) begin
          w_in_next     = 1'b0;
          w_close       = 1'b1;
          w_close_start = w_idx;
        end
      end
    end else if (data_in < w_thl) begin
      w_in_next   = 1'b0;
      w_close     = 1'b1;
      w_close_end = w_idx - 8'd1;
    end else if (w_idx == LAST_IDX) begin
      w_in_next = 1'b0;
      w_close   = 1'b1;
    end
  end

  assign w_width  = WID_W'(r_cl_end) - WID_W'(r_cl_start) + WID_W'(1);
  assign w_accept = r_cl_vld & (w_width >= WID_W'(MIN_WIDTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state              <= IDLE;
      r_idx                <= '0;
      r_cand_start         <= '0;
      r_cl_start           <= '0;
      r_cl_end             <= '0;
      r_cl_vld             <= 1'b0;
      r_in_region          <= 1'b0;
      r_last               <= 1'b0;
      r_th_high            <= '0;
      r_th_low             <= '0;
      r_sh_start           <= '0;
      r_sh_end             <= '0;
      r_count              <= '0;
      start_position_1     <= '0;
      start_position_2     <= '0;
      start_position_3     <= '0;
      end_position_1       <= '0;
      end_position_2       <= '0;
      end_position_3       <= '0;
      position_3_error_sig <= 1'b0;
      position_gen_en      <= 1'b0;
      busy                 <= 1'b0;
    end else begin
      position_gen_en <= 1'b0;
      r_cl_vld        <= 1'b0;

      // Acceptance runs one edge behind the tracker; a restart drops any pending close
      if (w_start_beat) begin
        r_state    <= SCAN;
        busy       <= 1'b1;
        r_last     <= 1'b0;
        r_th_high  <= th_high;
        r_th_low   <= th_low;
        r_sh_start <= '0;
        r_sh_end   <= '0;
        r_count    <= '0;
      end else if (w_accept) begin
        if (r_count < CNT_W'(3)) begin
          r_sh_start[r_count[1:0]] <= r_cl_start;
          r_sh_end[r_count[1:0]]   <= r_cl_end;
        end
        if (r_count < CNT_W'(4)) begin
          r_count <= r_count + CNT_W'(1);
        end
      end

      if (w_proc) begin
        r_in_region  <= w_in_next;
        r_cand_start <= w_cs_next;
        r_cl_vld     <= w_close;
        r_cl_start   <= w_close_start;
        r_cl_end     <= w_close_end;
        r_idx        <= w_idx + 8'd1;
        if (w_idx == LAST_IDX) begin
          r_last <= 1'b1;
        end
      end

      case (r_state)
        SCAN: begin
          if (r_last) begin
            r_state <= FINISH;
          end
        end
        FINISH: begin
          start_position_1     <= r_sh_start[0];
          start_position_2     <= r_sh_start[1];
          start_position_3     <= r_sh_start[2];
          end_position_1       <= r_sh_end[0];
          end_position_2       <= r_sh_end[1];
          end_position_3       <= r_sh_end[2];
          position_3_error_sig <= (r_count != CNT_W'(3));
          position_gen_en      <= 1'b1;
          busy                 <= 1'b0;
          r_last               <= 1'b0;
          r_state              <= IDLE;
        end
        default: ;
      endcase
    end
  end

endmodule
